// File: rtl/sim_end_monitor.sv
// sim_end_monitor: watches tohost stores for a sticky pass/fail/timeout verdict and counts RUN cycles and instret.
// The verdict shows 1 cycle after the qualifying store and the monitor never stalls the core. Optional console: MON_CONSOLE_EN.
module sim_end_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic             wb_valid,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic             con_valid,
  output logic [7:0]       con_data
);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  // Last RUN cycle value before expiry; the expiring edge still counts, so TIMEOUT reads N.
  localparam logic [CNT_W-1:0] LP_TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fail_latch;
  logic              w_run;
  logic              w_hit;
  logic              w_wd_exp;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_instret;
  logic [30:0]       r_fail_code;

  assign w_run    = (r_state == ST_RUN);
  assign w_hit    = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign w_wd_exp = (TIMEOUT_CYCLES != 0) && (r_cycle == LP_TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // A tohost hit outranks a same-cycle watchdog expiry; even-valued stores are ignored.
  always_comb begin
    w_state_nxt  = r_state;
    w_fail_latch = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_hit && (dmem_wdata == 32'h1)) begin
          w_state_nxt = ST_PASS;
        end else if (w_hit && dmem_wdata[0]) begin
          w_state_nxt  = ST_FAIL;
          w_fail_latch = 1'b1;
        end else if (w_wd_exp) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle     <= '0;
      r_instret   <= '0;
      r_fail_code <= '0;
    end else begin
      if (w_run) begin
        if (r_cycle != '1) r_cycle <= r_cycle + CNT_W'(1);
        if (wb_valid && (r_instret != '1)) r_instret <= r_instret + CNT_W'(1);
      end
      if (w_fail_latch) r_fail_code <= dmem_wdata[31:1];
    end
  end

`ifdef MON_CONSOLE_EN
  logic       w_con_hit;
  logic       r_con_valid;
  logic [7:0] r_con_data;

  assign w_con_hit = w_run && dmem_we && (dmem_addr == TOHOST_ADDR + 32'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_con_valid <= 1'b0;
      r_con_data  <= 8'h00;
    end else begin
      r_con_valid <= w_con_hit;
      if (w_con_hit) r_con_data <= dmem_wdata[7:0];
    end
  end

  assign con_valid = r_con_valid;
  assign con_data  = r_con_data;
`else
  assign con_valid = 1'b0;
  assign con_data  = 8'h00;
`endif

  assign done          = !w_run;
  assign pass          = (r_state == ST_PASS);
  assign fail          = (r_state == ST_FAIL);
  assign timeout       = (r_state == ST_TIMEOUT);
  assign fail_code     = r_fail_code;
  assign cycle_count   = r_cycle;
  assign instret_count = r_instret;

endmodule
